// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if
// Bundles the master-side request/response signals and the memory-side command/data
// signals of cpu_bus_arbiter. Master i occupies slice [i*W +: W] of each flattened vector.
//   master modport : the requesting masters plus the memory (drive requests, iMemRData)
//   slave  modport : the arbiter (drives grants, read returns and the memory command)
// Signals:
//   iReq/iWe/iAddr/iWData/iBE   per-master request, direction, address, write data, byte enables
//   oGnt/oRValid/oRData         one-hot accept strobe, one-hot read-valid, shared read data
//   oMemRead/oMemWrite/oMemAddr/oMemWData/oMemBE   registered memory command
//   iMemRData                   memory read data
//   oOutstanding                reads issued and not yet returned
interface cpu_bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]          iReq;
    logic [NUM_MASTERS-1:0]          iWe;
    logic [NUM_MASTERS*ADDR_W-1:0]   iAddr;
    logic [NUM_MASTERS*DATA_W-1:0]   iWData;
    logic [NUM_MASTERS*DATA_W/8-1:0] iBE;
    logic [NUM_MASTERS-1:0]          oGnt;
    logic [NUM_MASTERS-1:0]          oRValid;
    logic [DATA_W-1:0]               oRData;
    logic                            oMemRead;
    logic                            oMemWrite;
    logic [ADDR_W-1:0]               oMemAddr;
    logic [DATA_W-1:0]               oMemWData;
    logic [DATA_W/8-1:0]             oMemBE;
    logic [DATA_W-1:0]               iMemRData;
    logic [2:0]                      oOutstanding;

    modport master (
        output iReq, iWe, iAddr, iWData, iBE, iMemRData,
        input  oGnt, oRValid, oRData, oMemRead, oMemWrite, oMemAddr, oMemWData, oMemBE,
               oOutstanding
    );

    modport slave (
        input  iReq, iWe, iAddr, iWData, iBE, iMemRData,
        output oGnt, oRValid, oRData, oMemRead, oMemWrite, oMemAddr, oMemWData, oMemBE,
               oOutstanding
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// Merges NUM_MASTERS request buses (0 = instruction fetch, 1 = data, others optional) onto
// one single-ported memory bus. At most one request is accepted per cycle, either
// round-robin or fixed priority (lowest index). The accepted command is registered onto the
// memory bus; reads are tagged with the master index in a READ_LATENCY+1 deep pipeline so
// that the returning iMemRData is flagged to the right master.
// Ports:
//   iCLK    system clock
//   iRST    synchronous active-high reset
//   bus_if  slave modport of cpu_bus_arbiter_if (master requests, memory command, returns)
module cpu_bus_arbiter #(
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ARB_MODE     = 0
) (
    input logic              iCLK,
    input logic              iRST,
    cpu_bus_arbiter_if.slave bus_if
);
    localparam int unsigned IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned STAGES = READ_LATENCY + 1;
    localparam int unsigned LAST   = STAGES - 1;

    typedef logic [IDX_W-1:0] idx_t;

    idx_t              ptr_q, ptr_d;
    idx_t              gnt_idx;
    idx_t              cand;
    logic              gnt_any;
    logic              gnt_we;
    logic              rd_issue;
    logic              rd_retire;

    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;

    logic [STAGES-1:0] tag_vld_q, tag_vld_d;
    idx_t              tag_idx_q [STAGES];
    idx_t              tag_idx_d [STAGES];
    logic [2:0]        outst_q, outst_d;

    // Arbitration. Both searches walk downwards so the last hit written is the winner.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (ARB_MODE == 1) begin
            for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
                if (bus_if.iReq[i]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx_t'(i);
                end
            end
        end else begin
            // Offsets NUM_MASTERS..1 past the last grant; offset 1 is checked last, so the
            // requester nearest to ptr_q+1 wins and the last-granted master is tried last.
            for (int i = int'(NUM_MASTERS); i >= 1; i--) begin
                cand = idx_t'((int'(ptr_q) + i) % int'(NUM_MASTERS));
                if (bus_if.iReq[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (iRST) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        bus_if.oGnt = '0;
        if (gnt_any) begin
            bus_if.oGnt[gnt_idx] = 1'b1;
        end
    end

    assign gnt_we    = bus_if.iWe[gnt_idx];
    assign rd_issue  = gnt_any & ~gnt_we;
    assign rd_retire = tag_vld_q[LAST];

    always_comb begin
        ptr_d       = gnt_any ? gnt_idx : ptr_q;
        mem_read_d  = rd_issue;
        mem_write_d = gnt_any & gnt_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if (gnt_any) begin
            mem_addr_d  = bus_if.iAddr[int'(gnt_idx) * ADDR_W +: ADDR_W];
            mem_wdata_d = bus_if.iWData[int'(gnt_idx) * DATA_W +: DATA_W];
            mem_be_d    = bus_if.iBE[int'(gnt_idx) * BE_W +: BE_W];
        end

        // Tag pipeline shifts every cycle; stage 0 captures the read being accepted now.
        tag_vld_d    = '0;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = rd_issue;
        tag_idx_d[0] = gnt_idx;
        for (int s = 1; s < int'(STAGES); s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end

        unique case ({rd_issue, rd_retire})
            2'b10:   outst_d = outst_q + 3'd1;
            2'b01:   outst_d = outst_q - 3'd1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ptr_q       <= idx_t'(NUM_MASTERS - 1);
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            tag_vld_q   <= '0;
            tag_idx_q   <= '{default: '0};
            outst_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            outst_q     <= outst_d;
        end
    end

    always_comb begin
        bus_if.oRValid = '0;
        if (tag_vld_q[LAST]) begin
            bus_if.oRValid[tag_idx_q[LAST]] = 1'b1;
        end
    end

    assign bus_if.oRData       = bus_if.iMemRData;
    assign bus_if.oMemRead     = mem_read_q;
    assign bus_if.oMemWrite    = mem_write_q;
    assign bus_if.oMemAddr     = mem_addr_q;
    assign bus_if.oMemWData    = mem_wdata_q;
    assign bus_if.oMemBE       = mem_be_q;
    assign bus_if.oOutstanding = outst_q;
endmodule
